// File: rtl/otter_alu_arbiter_pkg.sv
// Shared widths and ALU function-select codes for the OtterMCU ALU and its arbiter.
// The codes mirror otter_defines.vh so every file in this slice agrees on one encoding.
package otter_alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 4;

    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_ADD  = 4'b0000;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_SLL  = 4'b0001;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_SLT  = 4'b0010;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_SLTU = 4'b0011;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_XOR  = 4'b0100;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_SRL  = 4'b0101;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_OR   = 4'b0110;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_AND  = 4'b0111;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_SUB  = 4'b1000;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_LUI  = 4'b1001;
    localparam logic [FUNC_W-1:0] ALU_FUNC_SEL_SRA  = 4'b1101;

    localparam logic [DATA_W-1:0] ALU_DEFAULT_RESULT = 32'hDEAD_DEAD;

endpackage

// File: rtl/otter_alu.sv
// Combinational OtterMCU ALU; unknown function codes yield ALU_DEFAULT_RESULT.
module otter_alu
    import otter_alu_arbiter_pkg::*;
(
    input  logic [FUNC_W-1:0] alu_fun,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = ALU_DEFAULT_RESULT;
        case (alu_fun)
            ALU_FUNC_SEL_ADD:  result = src_a + src_b;
            ALU_FUNC_SEL_SUB:  result = src_a - src_b;
            ALU_FUNC_SEL_OR:   result = src_a | src_b;
            ALU_FUNC_SEL_AND:  result = src_a & src_b;
            ALU_FUNC_SEL_XOR:  result = src_a ^ src_b;
            ALU_FUNC_SEL_SRL:  result = src_a >> src_b[4:0];
            ALU_FUNC_SEL_SLL:  result = src_a << src_b[4:0];
            ALU_FUNC_SEL_SRA:  result = $signed(src_a) >>> src_b[4:0];
            ALU_FUNC_SEL_SLT:  result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            ALU_FUNC_SEL_SLTU: result = (src_a < src_b) ? 32'd1 : 32'd0;
            ALU_FUNC_SEL_LUI:  result = src_a;
            default:           result = ALU_DEFAULT_RESULT;
        endcase
    end

endmodule

// File: rtl/otter_alu_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
module otter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/otter_alu_arbiter.sv
// Shares one otter_alu among NUM_REQ requesters with round-robin grant and a
// one-deep registered response that can be replaced in the same cycle it is taken.
module otter_alu_arbiter
    import otter_alu_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_src_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_src_b,
    input  logic [NUM_REQ*FUNC_W-1:0] i_req_func,
    input  logic                      i_flush,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_result,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic                      o_busy
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     rr_ptr, rsp_id, gnt_idx, ptr_next;
    logic [NUM_REQ-1:0]  grant;
    logic                gnt_any, rsp_hs, accept_en, accept;
    logic [DATA_W-1:0]   rsp_result, alu_a, alu_b, alu_result;
    logic [FUNC_W-1:0]   alu_func;

    otter_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .valid     (i_req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    // A held response frees the slot in the same cycle it is taken, so a new op
    // can be accepted back-to-back; flush always closes the window.
    always_comb begin
        rsp_hs      = (state == RESP) && i_rsp_ready[rsp_id];
        accept_en   = !i_flush && ((state == IDLE) || rsp_hs);
        accept      = accept_en && gnt_any;
        o_req_ready = (accept_en && !i_rst) ? grant : '0;
        ptr_next    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        alu_a       = i_req_src_a[DATA_W*gnt_idx +: DATA_W];
        alu_b       = i_req_src_b[DATA_W*gnt_idx +: DATA_W];
        alu_func    = i_req_func[FUNC_W*gnt_idx +: FUNC_W];
    end

    otter_alu u_alu (
        .alu_fun (alu_func),
        .src_a   (alu_a),
        .src_b   (alu_b),
        .result  (alu_result)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_result <= '0;
            rsp_id     <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            rsp_result <= alu_result;
            rsp_id     <= gnt_idx;
            rr_ptr     <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RESP;
            RESP: begin
                if (i_flush)     state_next = IDLE;
                else if (rsp_hs) state_next = accept ? RESP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response valid is derived from state so only the owner bit can ever be set.
    always_comb begin
        o_busy      = (state == RESP);
        o_rsp_valid = '0;
        if (state == RESP) o_rsp_valid[rsp_id] = 1'b1;
    end

    assign o_rsp_result = rsp_result;
    assign o_rsp_id     = rsp_id;

endmodule

// File: tb/tb_otter_alu_arbiter.sv
// Directed bench for otter_alu_arbiter with two requesters; expected values hand-computed.
module tb_otter_alu_arbiter;
    import otter_alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] src_a, src_b;
    logic [7:0]  func;
    logic        flush;
    logic [31:0] rsp_result;
    logic [0:0]  rsp_id;
    logic        busy;
    int          total = 0;
    int          bad   = 0;
    logic [1:0]  exp_own;

    otter_alu_arbiter #(.NUM_REQ(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_src_a  (src_a),
        .i_req_src_b  (src_b),
        .i_req_func   (func),
        .i_flush      (flush),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_id     (rsp_id),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rdy, input logic fl);
        req_valid = valid;
        rsp_ready = rdy;
        flush     = fl;
    endtask

    task automatic setOp(input int k, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            func[3:0] = f; src_a[31:0] = a; src_b[31:0] = b;
        end else begin
            func[7:4] = f; src_a[63:32] = a; src_b[63:32] = b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        src_a = '0; src_b = '0; func = '0;
        applyStimulus(2'b11, 2'b11, 1'b0);
        #2;
        checkOutput("reset_req_ready", {30'b0, req_ready}, 32'h0);
        checkOutput("reset_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        checkOutput("reset_result", rsp_result, 32'h0);
        checkOutput("reset_id", {31'b0, rsp_id}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        tick();
        rst = 1'b0;

        // single op on requester 0
        setOp(0, ALU_FUNC_SEL_ADD, 32'h1234_5678, 32'h8765_4321);
        applyStimulus(2'b01, 2'b11, 1'b0);
        #1;
        checkOutput("single_ready", {30'b0, req_ready}, 32'h1);
        tick();
        applyStimulus(2'b00, 2'b11, 1'b0);
        checkOutput("single_rsp_valid", {30'b0, rsp_valid}, 32'h1);
        checkOutput("single_id", {31'b0, rsp_id}, 32'h0);
        checkOutput("single_result", rsp_result, 32'h9999_9999);
        checkOutput("single_busy", {31'b0, busy}, 32'h1);
        tick();
        checkOutput("single_idle_valid", {30'b0, rsp_valid}, 32'h0);
        checkOutput("single_idle_busy", {31'b0, busy}, 32'h0);

        // contention straight after reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        setOp(0, ALU_FUNC_SEL_SUB, 32'h8765_4321, 32'h1234_5678);
        setOp(1, ALU_FUNC_SEL_XOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
        applyStimulus(2'b11, 2'b11, 1'b0);
        #1;
        checkOutput("cont_ready0", {30'b0, req_ready}, 32'h1);
        tick();
        checkOutput("cont_result0", rsp_result, 32'h7530_ECA9);
        checkOutput("cont_id0", {31'b0, rsp_id}, 32'h0);
        checkOutput("cont_valid0", {30'b0, rsp_valid}, 32'h1);
        #1;
        checkOutput("cont_ready1", {30'b0, req_ready}, 32'h2);
        tick();
        checkOutput("cont_result1", rsp_result, 32'hFFFF_FFFF);
        checkOutput("cont_id1", {31'b0, rsp_id}, 32'h1);
        checkOutput("cont_valid1", {30'b0, rsp_valid}, 32'h2);

        // fairness: eight back-to-back ops alternate 0,1,0,1...
        exp_own = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("fair_ready", {30'b0, req_ready}, {30'b0, exp_own});
            tick();
            checkOutput("fair_id", {31'b0, rsp_id}, (exp_own == 2'b01) ? 32'h0 : 32'h1);
            checkOutput("fair_result", rsp_result, (exp_own == 2'b01) ? 32'h7530_ECA9 : 32'hFFFF_FFFF);
            checkOutput("fair_busy", {31'b0, busy}, 32'h1);
            exp_own = {exp_own[0], exp_own[1]};
        end

        // backpressure: requester 0 holds its response while requester 1 waits
        setOp(0, ALU_FUNC_SEL_ADD, 32'h1, 32'h2);
        applyStimulus(2'b01, 2'b11, 1'b0);
        #1;
        checkOutput("bp_setup_ready", {30'b0, req_ready}, 32'h1);
        tick();
        setOp(1, ALU_FUNC_SEL_SUB, 32'd10, 32'd3);
        applyStimulus(2'b10, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_ready_blocked", {30'b0, req_ready}, 32'h0);
            tick();
            checkOutput("bp_result_hold", rsp_result, 32'h3);
            checkOutput("bp_id_hold", {31'b0, rsp_id}, 32'h0);
            checkOutput("bp_valid_hold", {30'b0, rsp_valid}, 32'h1);
        end
        applyStimulus(2'b10, 2'b11, 1'b0);
        #1;
        checkOutput("bp_release_ready", {30'b0, req_ready}, 32'h2);
        tick();
        checkOutput("bp_release_result", rsp_result, 32'h7);
        checkOutput("bp_release_id", {31'b0, rsp_id}, 32'h1);
        applyStimulus(2'b00, 2'b11, 1'b0);
        tick();
        checkOutput("bp_drain_valid", {30'b0, rsp_valid}, 32'h0);

        // invalid function code returns the default pattern as a normal response
        setOp(0, 4'b1111, 32'h1111_1111, 32'h2222_2222);
        applyStimulus(2'b01, 2'b11, 1'b0);
        #1;
        checkOutput("inv_ready", {30'b0, req_ready}, 32'h1);
        tick();
        applyStimulus(2'b00, 2'b11, 1'b0);
        checkOutput("inv_result", rsp_result, 32'hDEAD_DEAD);
        checkOutput("inv_valid", {30'b0, rsp_valid}, 32'h1);
        tick();
        checkOutput("inv_handshaken", {30'b0, rsp_valid}, 32'h0);

        // flush in RESP drops the response and leaves the pointer alone
        setOp(1, ALU_FUNC_SEL_ADD, 32'd5, 32'd6);
        applyStimulus(2'b10, 2'b11, 1'b0);
        #1;
        checkOutput("flush_setup_ready", {30'b0, req_ready}, 32'h2);
        tick();
        checkOutput("flush_setup_result", rsp_result, 32'hB);
        setOp(0, ALU_FUNC_SEL_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        applyStimulus(2'b11, 2'b11, 1'b1);
        #1;
        checkOutput("flush_ready_blocked", {30'b0, req_ready}, 32'h0);
        tick();
        checkOutput("flush_valid", {30'b0, rsp_valid}, 32'h0);
        checkOutput("flush_busy", {31'b0, busy}, 32'h0);
        applyStimulus(2'b11, 2'b11, 1'b0);
        #1;
        checkOutput("flush_ptr_kept", {30'b0, req_ready}, 32'h1);
        tick();
        checkOutput("flush_next_id", {31'b0, rsp_id}, 32'h0);
        checkOutput("flush_next_result", rsp_result, 32'h0F00_0F00);

        // asynchronous reset in the middle of RESP
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", {30'b0, rsp_valid}, 32'h0);
        checkOutput("rst_mid_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_mid_result", rsp_result, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("rst_after_ready", {30'b0, req_ready}, 32'h1);
        tick();
        checkOutput("rst_after_id", {31'b0, rsp_id}, 32'h0);
        checkOutput("rst_after_valid", {30'b0, rsp_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
